// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared constants and helpers for the issue-side
// scoreboard. Register-file geometry, the zero-register index, and the
// forwarding-mux select codes shared with the EX/MEM/WB forwarding path.
// The forwarding codes are not used by the scoreboard itself.
package hazard_scoreboard_pkg;

  localparam int SB_REGS  = 32;
  localparam int SB_IDX_W = 5;
  localparam logic [SB_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FORWARD_NONE   = 2'd0,
    FORWARD_EX_MEM = 2'd1,
    FORWARD_MEM_WB = 2'd2
  } forward_e;

  // One-hot decode of a register index into a scoreboard-wide vector.
  function automatic logic [SB_REGS-1:0] reg_onehot(input logic [SB_IDX_W-1:0] idx);
    reg_onehot = SB_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request, WB retire port and scoreboard
// status bundled together.
//   master : decoder/writeback side (drives id_* and wb_*, sees stall/issue/status)
//   slave  : the scoreboard
// MAX_PENDING must match the scoreboard instance; it sizes pending_count.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_PENDING = 4
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic                id_valid;
  logic [SB_IDX_W-1:0] id_rs1;
  logic [SB_IDX_W-1:0] id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [SB_IDX_W-1:0] id_rd;
  logic                id_reg_write;
  logic                id_long;
  logic                id_flush;
  logic                wb_valid;
  logic [SB_IDX_W-1:0] wb_rd;
  logic                stall;
  logic                issue;
  logic [SB_REGS-1:0]  pending_mask;
  logic [CNT_W-1:0]    pending_count;
  logic                sb_error;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_long, id_flush, wb_valid, wb_rd,
    input  stall, issue, pending_mask, pending_count, sb_error
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_long, id_flush, wb_valid, wb_rd,
    output stall, issue, pending_mask, pending_count, sb_error
  );

endinterface

// File: rtl/hazard_scoreboard_sb_hazard_check.sv
// hazard_scoreboard_sb_hazard_check: combinational RAW/WAW detection of one
// ID slot against an effective pending vector. Kept separate so a second
// issue slot can instantiate another copy against the same vector.
//   eff            : pending bits after retire bypass
//   rs1/rs2/rd     : ID register indices with their use/write qualifiers
//   raw1/raw2/waw  : hazard flags (x0 never hazards)
module hazard_scoreboard_sb_hazard_check
  import hazard_scoreboard_pkg::*;
(
  input  logic [SB_REGS-1:0]  eff,
  input  logic                use_rs1,
  input  logic [SB_IDX_W-1:0] rs1,
  input  logic                use_rs2,
  input  logic [SB_IDX_W-1:0] rs2,
  input  logic                reg_write,
  input  logic [SB_IDX_W-1:0] rd,
  output logic                raw1,
  output logic                raw2,
  output logic                waw
);

  assign raw1 = use_rs1   & (rs1 != REG_ZERO) & eff[rs1];
  assign raw2 = use_rs2   & (rs2 != REG_ZERO) & eff[rs2];
  assign waw  = reg_write & (rd  != REG_ZERO) & eff[rd];

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-side interlock for long-latency writers (loads,
// mul/div). Holds one pending bit per architectural register from issue to
// writeback and stalls ID on RAW/WAW against pending registers, or when the
// in-flight budget is exhausted.
//   clk, rst_n : clock, async active-low reset
//   sb (slave) : ID request, WB retire, stall/issue, pending_mask,
//                pending_count, sticky sb_error
// stall/issue are combinational; scoreboard state updates on the next edge.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter bit WB_BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave sb
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [SB_REGS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [SB_REGS-1:0] wb_oh, eff, set_oh, clr_oh;
  logic bypass, raw1, raw2, waw, full, stall, issue;
  logic wb_nz, wb_hit, set_ev, clr_ev, bad_ev;

  // A register retiring this cycle is visible to ID through the MEM/WB
  // forward, so it does not block when bypass is enabled.
  assign wb_oh  = reg_onehot(sb.wb_rd);
  assign bypass = WB_BYPASS & sb.wb_valid;
  assign eff    = bypass ? (mask_q & ~wb_oh) : mask_q;

  hazard_scoreboard_sb_hazard_check u_chk (
    .eff       (eff),
    .use_rs1   (sb.id_use_rs1),
    .rs1       (sb.id_rs1),
    .use_rs2   (sb.id_use_rs2),
    .rs2       (sb.id_rs2),
    .reg_write (sb.id_reg_write),
    .rd        (sb.id_rd),
    .raw1      (raw1),
    .raw2      (raw2),
    .waw       (waw)
  );

  // Budget gate: a concurrent retire frees a slot, so full is lifted then.
  assign full  = sb.id_long & sb.id_reg_write & (sb.id_rd != REG_ZERO) &
                 (cnt_q == CNT_MAX) & ~bypass;
  assign stall = sb.id_valid & ~sb.id_flush & (raw1 | raw2 | waw | full);
  assign issue = sb.id_valid & ~sb.id_flush & ~stall;

  assign set_ev = issue & sb.id_long & sb.id_reg_write & (sb.id_rd != REG_ZERO);
  assign wb_nz  = sb.wb_valid & (sb.wb_rd != REG_ZERO);
  assign wb_hit = mask_q[sb.wb_rd];
  assign clr_ev = wb_nz & wb_hit;
  assign bad_ev = wb_nz & ~wb_hit;
  assign set_oh = set_ev ? reg_onehot(sb.id_rd) : '0;
  assign clr_oh = clr_ev ? wb_oh : '0;

  always_comb begin
    // Set applied after clear: re-issue to the retiring register keeps it.
    mask_d    = (mask_q & ~clr_oh) | set_oh;
    mask_d[0] = 1'b0;
    cnt_d     = cnt_q;
    case ({set_ev, clr_ev})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | bad_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign sb.stall         = stall;
  assign sb.issue         = issue;
  assign sb.pending_mask  = mask_q;
  assign sb.pending_count = cnt_q;
  assign sb.sb_error      = err_q;

endmodule
